// File: rtl/vending_fsm_multi_if.sv
// Bundle of all vending machine front-end and back-end signals
// (coin, keypad, restock, dispenser and hopper).
// The master side is the environment; the slave side is the FSM.
interface vending_fsm_multi_if #(
  parameter int CODE_W   = 2,
  parameter int COUNT_W  = 3,
  parameter int MONEY_W  = 4,
  parameter int CREDIT_W = 8,
  parameter int STOCK_W  = 4
);
  logic                coin_valid;
  logic [MONEY_W-1:0]  coin_value;
  logic                coin_reject;
  logic                sel_valid;
  logic [CODE_W-1:0]   sel_code;
  logic [COUNT_W-1:0]  sel_count;
  logic                cancel;
  logic                restock_valid;
  logic [CODE_W-1:0]   restock_code;
  logic [STOCK_W-1:0]  restock_count;
  logic                posibility;
  logic                sel_reject;
  logic                dispense_valid;
  logic [CODE_W-1:0]   dispense_code;
  logic [COUNT_W-1:0]  dispense_count;
  logic                dispense_ready;
  logic                change_valid;
  logic [CREDIT_W-1:0] remaining;
  logic                change_ready;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_code, sel_count, cancel,
           restock_valid, restock_code, restock_count, dispense_ready, change_ready,
    input  coin_reject, posibility, sel_reject, dispense_valid, dispense_code,
           dispense_count, change_valid, remaining, credit
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_code, sel_count, cancel,
           restock_valid, restock_code, restock_count, dispense_ready, change_ready,
    output coin_reject, posibility, sel_reject, dispense_valid, dispense_code,
           dispense_count, change_valid, remaining, credit
  );
endinterface

// File: rtl/vending_fsm_multi.sv
// Vending machine controller: accumulates coin credit, checks a selection
// against price and stock, then hands dispense and change off over valid/ready.
// Selection result pulses 2 edges after the request; outputs hold until ready.
module vending_fsm_multi #(
  parameter int N_ITEMS  = 4,
  parameter int CODE_W   = 2,
  parameter int COUNT_W  = 3,
  parameter int MONEY_W  = 4,
  parameter int CREDIT_W = 8,
  parameter int STOCK_W  = 4,
  parameter logic [STOCK_W-1:0] STOCK_INIT = 4'd5,
  // item i lives at [i*MONEY_W +: MONEY_W]: item0=3, item1=4, item2=5, item3=6
  parameter logic [N_ITEMS*MONEY_W-1:0] PRICES = {4'd6, 4'd5, 4'd4, 4'd3}
) (
  input  logic clk,
  input  logic rst_n,
  vending_fsm_multi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, CHANGE} state_t;

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_q, credit_nx;
  logic [CODE_W-1:0]   code_q;
  logic [COUNT_W-1:0]  count_q;
  logic [STOCK_W-1:0]  stock    [N_ITEMS];
  logic [STOCK_W-1:0]  stock_nx [N_ITEMS];
  logic                coin_reject_q, posibility_q, sel_reject_q;

  // coin acceptance: only in IDLE and only if the credit cannot wrap
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok, coin_rej;
  logic [CREDIT_W-1:0] credit_after_coin;

  // selection evaluation for the latched code/count
  logic                code_in_range;
  logic [MONEY_W-1:0]  price;
  logic [STOCK_W-1:0]  stock_sel;
  logic [CREDIT_W-1:0] price_ext, count_ext, cost;
  logic                sel_ok, accept, reject;

  // coin arithmetic, done one bit wider so overflow is visible
  always_comb begin
    coin_sum          = {1'b0, credit_q} + {{(CREDIT_W+1-MONEY_W){1'b0}}, bus.coin_value};
    coin_ok           = bus.coin_valid && (state == IDLE) && !coin_sum[CREDIT_W];
    coin_rej          = bus.coin_valid && !coin_ok;
    credit_after_coin = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
  end

  // price/stock lookup and the accept/reject decision made in CHECK
  always_comb begin
    code_in_range = 1'b0;
    price         = '0;
    stock_sel     = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (code_q == CODE_W'(i)) begin
        code_in_range = 1'b1;
        price         = PRICES[i*MONEY_W +: MONEY_W];
        stock_sel     = stock[i];
      end
    end
    price_ext = {{(CREDIT_W-MONEY_W){1'b0}}, price};
    count_ext = {{(CREDIT_W-COUNT_W){1'b0}}, count_q};
    cost      = price_ext * count_ext;
    sel_ok    = (count_q != '0) && code_in_range &&
                !(32'(stock_sel) < 32'(count_q)) && !(credit_q < cost);
    accept    = (state == CHECK) && sel_ok;
    reject    = (state == CHECK) && !sel_ok;
  end

  // stock update: CHECK decrement and restock merge in one step, then saturate
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      logic [STOCK_W:0] tmp;
      tmp = {1'b0, stock[i]};
      if (accept && (code_q == CODE_W'(i)))
        tmp = tmp - (STOCK_W+1)'(count_q);
      if (bus.restock_valid && (bus.restock_code == CODE_W'(i)))
        tmp = tmp + {1'b0, bus.restock_count};
      stock_nx[i] = tmp[STOCK_W] ? {STOCK_W{1'b1}} : tmp[STOCK_W-1:0];
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state and next-credit logic
  always_comb begin
    state_nx  = state;
    credit_nx = credit_q;
    unique case (state)
      IDLE: begin
        credit_nx = credit_after_coin;
        if (bus.cancel)         state_nx = (credit_after_coin != '0) ? CHANGE : IDLE;
        else if (bus.sel_valid) state_nx = CHECK;
      end
      CHECK: begin
        if (accept) begin
          credit_nx = credit_q - cost;
          state_nx  = DISPENSE;
        end else begin
          state_nx  = IDLE;
        end
      end
      DISPENSE: begin
        if (bus.dispense_ready) state_nx = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (bus.change_ready) begin
          credit_nx = '0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath registers: credit, latched selection, stock, result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q      <= '0;
      code_q        <= '0;
      count_q       <= '0;
      coin_reject_q <= 1'b0;
      posibility_q  <= 1'b0;
      sel_reject_q  <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_INIT;
    end else begin
      credit_q      <= credit_nx;
      coin_reject_q <= coin_rej;
      posibility_q  <= accept;
      sel_reject_q  <= reject;
      if ((state == IDLE) && bus.sel_valid && !bus.cancel) begin
        code_q  <= bus.sel_code;
        count_q <= bus.sel_count;
      end
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= stock_nx[i];
    end
  end

  // outputs: handshake requests decoded from state, data zeroed when not valid
  always_comb begin
    bus.coin_reject    = coin_reject_q;
    bus.posibility     = posibility_q;
    bus.sel_reject     = sel_reject_q;
    bus.dispense_valid = (state == DISPENSE);
    bus.dispense_code  = (state == DISPENSE) ? code_q  : '0;
    bus.dispense_count = (state == DISPENSE) ? count_q : '0;
    bus.change_valid   = (state == CHANGE);
    bus.remaining      = (state == CHANGE) ? credit_q : '0;
    bus.credit         = credit_q;
  end

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Directed bench for vending_fsm_multi with an event scoreboard:
// expected pulses/handshakes are queued as stimulus is applied and
// popped by a monitor sampling on the falling clock edge.
module tb_vending_fsm_multi;

  localparam int K_POS = 1, K_SREJ = 2, K_CREJ = 3, K_DISP = 4, K_CHG = 5;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  ev_t  exp_q[$];

  vending_fsm_multi_if bus ();

  vending_fsm_multi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int a, input int b);
    ev_t e;
    e.kind = 0; e.a = 0; e.b = 0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    n_checks++;
    assert (kind == e.kind && a == e.a && b == e.b) else begin
      n_err++;
      $error("FAIL event: observed kind %0d (%0d,%0d) expected kind %0d (%0d,%0d)",
             kind, a, b, e.kind, e.a, e.b);
    end
  endtask

  // monitor: one scoreboard pop per observed pulse or completed handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.posibility)  got(K_POS, 0, 0);
      if (bus.sel_reject)  got(K_SREJ, 0, 0);
      if (bus.coin_reject) got(K_CREJ, 0, 0);
      if (bus.dispense_valid && bus.dispense_ready)
        got(K_DISP, 32'(bus.dispense_code), 32'(bus.dispense_count));
      if (bus.change_valid && bus.change_ready)
        got(K_CHG, 32'(bus.remaining), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    bus.coin_valid = 1'b1;
    bus.coin_value = 4'(v);
    tick();
    bus.coin_valid = 1'b0;
  endtask

  // issues a selection and steps through CHECK to the result edge
  task automatic select(input int code, input int count, input int expect_kind);
    push(expect_kind, 0, 0);
    bus.sel_valid = 1'b1;
    bus.sel_code  = 2'(code);
    bus.sel_count = 3'(count);
    tick();
    bus.sel_valid = 1'b0;
    tick();
  endtask

  task automatic take_dispense(input int code, input int count);
    push(K_DISP, code, count);
    bus.dispense_ready = 1'b1;
    tick();
    bus.dispense_ready = 1'b0;
  endtask

  task automatic wait_change(input int budget);
    int n = 0;
    while (!bus.change_valid && n < budget) begin
      tick();
      n++;
    end
    chk("change_wait", 32'(bus.change_valid), 1);
  endtask

  task automatic take_change(input int amount);
    push(K_CHG, amount, 0);
    bus.change_ready = 1'b1;
    tick();
    bus.change_ready = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_coin_rej"}, 32'(bus.coin_reject), 0);
    chk({tag, "_pos"},      32'(bus.posibility), 0);
    chk({tag, "_sel_rej"},  32'(bus.sel_reject), 0);
    chk({tag, "_disp_v"},   32'(bus.dispense_valid), 0);
    chk({tag, "_disp_cd"},  32'(bus.dispense_code), 0);
    chk({tag, "_disp_ct"},  32'(bus.dispense_count), 0);
    chk({tag, "_chg_v"},    32'(bus.change_valid), 0);
    chk({tag, "_remain"},   32'(bus.remaining), 0);
    chk({tag, "_credit"},   32'(bus.credit), 0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n              = 1'b0;
    bus.coin_valid     = 1'b0;
    bus.coin_value     = '0;
    bus.sel_valid      = 1'b0;
    bus.sel_code       = '0;
    bus.sel_count      = '0;
    bus.cancel         = 1'b0;
    bus.restock_valid  = 1'b0;
    bus.restock_code   = '0;
    bus.restock_count  = '0;
    bus.dispense_ready = 1'b0;
    bus.change_ready   = 1'b0;

    // reset state
    tick();
    tick();
    chk_outputs_zero("rst");
    for (int i = 0; i < 4; i++) chk("rst_stock", 32'(dut.stock[i]), 5);
    rst_n = 1'b1;
    tick();

    // 5+5, buy 2 of item 1 at 4 -> change 2
    coin(5);
    coin(5);
    chk("t1_credit", 32'(bus.credit), 10);
    select(1, 2, K_POS);
    chk("t1_disp_v", 32'(bus.dispense_valid), 1);
    chk("t1_credit_after", 32'(bus.credit), 2);
    chk("t1_stock1", 32'(dut.stock[1]), 3);
    take_dispense(1, 2);
    chk("t1_chg_v", 32'(bus.change_valid), 1);
    chk("t1_remaining", 32'(bus.remaining), 2);
    take_change(2);
    chk("t1_credit_end", 32'(bus.credit), 0);

    // insufficient credit: 3 of item 2 costs 15 with 10 inserted
    coin(5);
    coin(5);
    select(2, 3, K_SREJ);
    chk("t2_credit", 32'(bus.credit), 10);
    chk("t2_stock2", 32'(dut.stock[2]), 5);

    // zero count and more than in stock
    select(0, 0, K_SREJ);
    select(3, 6, K_SREJ);
    chk("t3_stock0", 32'(dut.stock[0]), 5);
    chk("t3_stock3", 32'(dut.stock[3]), 5);
    chk("t3_credit", 32'(bus.credit), 10);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    wait_change(4);
    chk("t3_remaining", 32'(bus.remaining), 10);
    take_change(10);

    // credit overflow: 250 + 15 is refused
    for (int i = 0; i < 16; i++) coin(15);
    coin(10);
    chk("t4_credit", 32'(bus.credit), 250);
    push(K_CREJ, 0, 0);
    coin(15);
    chk("t4_credit_kept", 32'(bus.credit), 250);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    wait_change(4);
    chk("t4_remaining", 32'(bus.remaining), 250);
    take_change(250);
    chk("t4_credit_end", 32'(bus.credit), 0);

    // restock saturates at 15
    bus.restock_valid = 1'b1;
    bus.restock_code  = 2'd0;
    bus.restock_count = 4'd15;
    tick();
    bus.restock_valid = 1'b0;
    chk("t6_stock0", 32'(dut.stock[0]), 15);

    // dispenser backpressure: outputs held, coins refused meanwhile
    coin(5);
    select(0, 1, K_POS);
    for (int i = 0; i < 5; i++) begin
      push(K_CREJ, 0, 0);
      bus.coin_valid = 1'b1;
      bus.coin_value = 4'd1;
      tick();
      chk("t5_disp_v", 32'(bus.dispense_valid), 1);
      chk("t5_disp_cd", 32'(bus.dispense_code), 0);
      chk("t5_disp_ct", 32'(bus.dispense_count), 1);
      chk("t5_credit", 32'(bus.credit), 2);
    end
    bus.coin_valid = 1'b0;
    take_dispense(0, 1);
    take_change(2);
    chk("t5_stock0", 32'(dut.stock[0]), 14);

    // reset in the middle of a dispense
    coin(5);
    select(1, 1, K_POS);
    tick();
    chk("t8_disp_v", 32'(bus.dispense_valid), 1);
    chk("t8_queue", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t8");
    chk("t8_stock1", 32'(dut.stock[1]), 5);
    tick();
    rst_n = 1'b1;
    tick();

    // restock coinciding with the CHECK decrement of the same item
    coin(15);
    push(K_POS, 0, 0);
    bus.sel_valid = 1'b1;
    bus.sel_code  = 2'd1;
    bus.sel_count = 3'd3;
    tick();
    bus.sel_valid     = 1'b0;
    bus.restock_valid = 1'b1;
    bus.restock_code  = 2'd1;
    bus.restock_count = 4'd2;
    tick();
    bus.restock_valid = 1'b0;
    chk("t7_stock1", 32'(dut.stock[1]), 4);
    chk("t7_credit", 32'(bus.credit), 3);
    take_dispense(1, 3);
    take_change(3);

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
